decode_scoreboard: RTL
======================

Name: decode_scoreboard

Overview:
- Register scoreboard and issue controller sitting between the Decoder and the execute stage.
- Tracks which architectural registers have an outstanding write.
- Each cycle, decides whether the decoded instruction (addr_r1, addr_r2, addr_rd, register_write) may issue, or whether decode must stall.
- Write-back retires pending entries. Flush discards all in-flight state.

Parameters:
- REG_ADDRESS_SIZE, 5, width of a register address.
- NUM_REGS, 32, number of architectural registers; must equal 2**REG_ADDRESS_SIZE.
- MAX_INFLIGHT, 4, maximum outstanding register writes; range 1..NUM_REGS-1.
- ZERO_REG, 1, when 1 register 0 is hardwired: never pending, never causes a hazard.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- dec_valid  in  1  Decoder presents a valid instruction this cycle.
- addr_r1  in  REG_ADDRESS_SIZE  source register 1 from Decoder.
- addr_r2  in  REG_ADDRESS_SIZE  source register 2 from Decoder.
- use_r1  in  1  instruction reads addr_r1.
- use_r2  in  1  instruction reads addr_r2.
- addr_rd  in  REG_ADDRESS_SIZE  destination register from Decoder.
- register_write  in  1  instruction writes addr_rd.
- wb_valid  in  1  write-back stage retires a register write this cycle.
- wb_addr  in  REG_ADDRESS_SIZE  register written back.
- flush  in  1  discard all outstanding writes (branch mispredict / exception).
- stall  out  1  hold Decoder; instruction must not advance.
- issue  out  1  instruction accepted this cycle.
- inflight_count  out  log2(MAX_INFLIGHT)+1  number of outstanding writes.
- wb_error  out  1  sticky: a write-back arrived for a non-pending register.

Behaviour:
- State: pending[NUM_REGS] bit vector, inflight_count register, wb_error register.
- Reset: pending all 0, inflight_count 0, wb_error 0. While reset is high, stall=0 and issue=0 regardless of inputs.
- Hazard evaluation (combinational, registered state only; no same-cycle write-back bypass):
  - raw1 = use_r1 & pending[addr_r1]; raw2 = use_r2 & pending[addr_r2].
  - waw = register_write & pending[addr_rd].
  - full = register_write & (inflight_count == MAX_INFLIGHT).
  - With ZERO_REG=1, any term whose address is 0 is forced 0.
- stall = dec_valid & ~flush & (raw1 | raw2 | waw | full).
- issue = dec_valid & ~flush & ~stall.
- Both stall and issue are 0 when dec_valid=0.
- Issue effect: if issue & register_write & rd_effective≠0, set pending[addr_rd] next edge and increment inflight_count.
  - rd_effective≠0 is true whenever ZERO_REG=0.
  - Issue with register_write=0, or with rd=0 when ZERO_REG=1, changes no state.
- Write-back effect: if wb_valid & pending[wb_addr], clear pending[wb_addr] next edge and decrement inflight_count.
  - If wb_valid & ~pending[wb_addr] (including wb_addr=0 with ZERO_REG=1 and ~pending): no state change; wb_error set to 1 and held until reset.
- Simultaneous write-back and issue:
  - Count update = +issue_w − wb_hit (net 0 when both occur).
  - Same register on both sides is impossible by the waw rule, since the stall uses registered pending. Write-back frees the register; the stalled instruction issues on the following cycle (1-cycle wb-to-issue latency).
- Flush:
  - Next edge, all pending bits and inflight_count go to 0.
  - stall=0 and issue=0 in the flush cycle.
  - Write-back in the same cycle is ignored and does not set wb_error.
  - Flush has priority over issue and write-back.
- Counter never exceeds MAX_INFLIGHT and never underflows; no wrap-around.
- Reset mid-operation: all state is cleared on that edge; outstanding write-backs arriving afterwards set wb_error (expected; the bench must re-reset or ignore).
- Stall is registered-state-driven. Decoder inputs must be held stable while stall=1; no other handshake.

Test Plan:
- Reset then idle, dec_valid=0 → stall=0, issue=0, inflight_count=0, wb_error=0.
- Issue rd=3 write; next cycle r1=3, use_r1=1 → stall=1. wb_valid, wb_addr=3 at cycle 5 → issue=1 at cycle 6, inflight_count 1→0.
- Issue writes to r1, r2, r4, r5 (MAX_INFLIGHT=4); fifth write to r6 → stall=1, count=4. Non-writing instruction with no hazard → issue=1. Write-back r2 → r6 issues next cycle, count stays 4.
- ZERO_REG=1: write rd=0, then read r1=0 → issue both cycles, count=0, pending[0]=0.
- Issue writes r7 and r8, then flush with dec_valid=1 → issue=0 that cycle, count=0 next. Later wb r7 → wb_error=1 and stays 1.
- Simultaneous wb r9 and issue of a write to r10 (no hazard) → count unchanged, pending[9]=0, pending[10]=1.

Source files
------------

// File: rtl/decode_scoreboard.sv
// Register scoreboard and issue controller between decode and execute.
// Tracks outstanding register writes and stalls decode on RAW, WAW or capacity hazards.
module decode_scoreboard #(
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int NUM_REGS         = 32,
    parameter int MAX_INFLIGHT     = 4,
    parameter bit ZERO_REG         = 1'b1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                dec_valid,
    input  logic [REG_ADDRESS_SIZE-1:0]         addr_r1,
    input  logic [REG_ADDRESS_SIZE-1:0]         addr_r2,
    input  logic                                use_r1,
    input  logic                                use_r2,
    input  logic [REG_ADDRESS_SIZE-1:0]         addr_rd,
    input  logic                                register_write,
    input  logic                                wb_valid,
    input  logic [REG_ADDRESS_SIZE-1:0]         wb_addr,
    input  logic                                flush,
    output logic                                stall,
    output logic                                issue,
    output logic [$clog2(MAX_INFLIGHT):0]       inflight_count,
    output logic                                wb_error
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0] pending;

    logic raw1, raw2, waw, full;
    logic issue_w, wb_hit, wb_miss;

    // Register 0 never participates in hazards when it is hardwired.
    function automatic logic is_live(input logic [REG_ADDRESS_SIZE-1:0] addr);
        return !ZERO_REG || (addr != '0);
    endfunction

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        raw1    = 1'b0;
        raw2    = 1'b0;
        waw     = 1'b0;
        full    = 1'b0;
        stall   = 1'b0;
        issue   = 1'b0;
        issue_w = 1'b0;
        wb_hit  = 1'b0;
        wb_miss = 1'b0;

        raw1 = use_r1 & pending[addr_r1] & is_live(addr_r1);
        raw2 = use_r2 & pending[addr_r2] & is_live(addr_r2);
        waw  = register_write & pending[addr_rd] & is_live(addr_rd);
        full = register_write & (inflight_count == CNT_MAX);

        stall   = ~reset & dec_valid & ~flush & (raw1 | raw2 | waw | full);
        issue   = ~reset & dec_valid & ~flush & ~(raw1 | raw2 | waw | full);
        issue_w = issue & register_write & is_live(addr_rd);

        // Flush discards write-backs entirely, including their error reporting.
        wb_hit  = wb_valid & ~flush &  pending[wb_addr];
        wb_miss = wb_valid & ~flush & ~pending[wb_addr];
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending        <= '0;
            inflight_count <= '0;
            wb_error       <= 1'b0;
        end else if (flush) begin
            pending        <= '0;
            inflight_count <= '0;
        end else begin
            if (issue_w) pending[addr_rd] <= 1'b1;
            if (wb_hit)  pending[wb_addr] <= 1'b0;

            // A write-back and an issue in the same cycle cancel out.
            case ({issue_w, wb_hit})
                2'b10:   inflight_count <= inflight_count + CNT_ONE;
                2'b01:   inflight_count <= inflight_count - CNT_ONE;
                default: inflight_count <= inflight_count;
            endcase

            wb_error <= wb_error | wb_miss;
        end
    end

endmodule
